// File: rtl/pq_pkg.sv
// pq_pkg: shared types and constants for the priority-queue device interface
// and its host-side sequencer.
//   kv_t        key/value pair exchanged with the PQ device
//   KEY0/VAL0   idle value driven on unused key/value buses
//   host_st_t   pq_sort_host state encoding, visible to benches for probing
package pq_pkg;

  localparam int unsigned KEY_WIDTH   = 8;
  localparam int unsigned VAL_WIDTH   = 8;
  localparam int unsigned PQ_CAPACITY = 8;

  localparam logic [KEY_WIDTH-1:0] KEY0 = '0;
  localparam logic [VAL_WIDTH-1:0] VAL0 = '0;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] val;
  } kv_t;

  localparam kv_t KV0 = '{key: KEY0, val: VAL0};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_GAP,
    DRAIN_RD,
    DRAIN_OUT
  } host_st_t;

endpackage

// File: rtl/pq_sort_host.sv
// pq_sort_host: batch sorter built on an attached priority-queue device.
// Accepts a batch of key/value pairs, enqueues each into the device, then
// dequeues the whole batch and emits it in ascending key order.
//   clk, rst            clock; asynchronous active-low reset
//   in_valid/in_ready   input stream handshake; in_kv item, in_last ends batch
//   out_valid/out_ready output stream handshake; out_kv/out_last registered
//   pq_enq/pq_deq/pq_kvi  commands and enqueue data towards the device
//   pq_kvo/pq_full/pq_empty/pq_busy  device head and status
//   batch_len           item count of the current or most recent batch
//   err                 sticky; truncated batch or device underrun
module pq_sort_host
  import pq_pkg::*;
#(
  parameter  int unsigned MAX_BATCH = PQ_CAPACITY,
  localparam int unsigned CW        = $clog2(MAX_BATCH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  kv_t           in_kv,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output kv_t           out_kv,
  output logic          out_last,
  output logic          pq_enq,
  output logic          pq_deq,
  output kv_t           pq_kvi,
  input  kv_t           pq_kvo,
  input  logic          pq_full,
  input  logic          pq_empty,
  input  logic          pq_busy,
  output logic [CW-1:0] batch_len,
  output logic          err
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BATCH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  host_st_t      state, state_nx;
  logic [CW-1:0] cnt;
  logic          last_seen;   // last accepted item carried in_last
  logic          first_pend;  // next accept opens a new batch
  logic          rdy;
  logic          accept;
  logic          take;
  logic          err_set;

  always_comb begin
    state_nx  = state;
    rdy       = 1'b0;
    out_valid = 1'b0;
    pq_enq    = 1'b0;
    pq_deq    = 1'b0;
    pq_kvi    = KV0;
    accept    = 1'b0;
    take      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: state_nx = LOAD;
      LOAD: begin
        rdy = !pq_busy && !pq_full && (cnt < CNT_MAX);
        if (in_valid && rdy) begin
          accept   = 1'b1;
          pq_enq   = 1'b1;
          pq_kvi   = in_kv;
          state_nx = LOAD_GAP;
        end else if (!pq_busy && pq_full) begin
          // Device filled before the batch ended: drain what was loaded,
          // leaving the pending input for the next batch.
          err_set  = 1'b1;
          state_nx = (cnt != '0) ? DRAIN_RD : IDLE;
        end
      end
      // One dead cycle so a busy flag raised by the last command is seen.
      LOAD_GAP: begin
        if (last_seen || cnt == CNT_MAX) begin
          err_set  = !last_seen;
          state_nx = DRAIN_RD;
        end else begin
          state_nx = LOAD;
        end
      end
      DRAIN_RD: begin
        if (!pq_busy) begin
          if (!pq_empty) begin
            take     = 1'b1;
            pq_deq   = 1'b1;
            state_nx = DRAIN_OUT;
          end else begin
            err_set  = (cnt != '0);
            state_nx = IDLE;
          end
        end
      end
      DRAIN_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = (cnt == CNT_ONE) ? IDLE : DRAIN_RD;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      batch_len  <= '0;
      err        <= 1'b0;
      out_kv     <= KV0;
      out_last   <= 1'b0;
      last_seen  <= 1'b0;
      first_pend <= 1'b0;
    end else begin
      if (state == IDLE) begin
        cnt        <= '0;
        last_seen  <= 1'b0;
        first_pend <= 1'b1;
      end
      if (accept) begin
        cnt        <= cnt + CNT_ONE;
        last_seen  <= in_last;
        first_pend <= 1'b0;
        if (first_pend) begin
          batch_len <= CNT_ONE;
          err       <= 1'b0;
        end else begin
          batch_len <= batch_len + CNT_ONE;
        end
      end
      if (err_set) err <= 1'b1;
      if (take) begin
        out_kv   <= pq_kvo;
        out_last <= (cnt == CNT_ONE);
      end
      if (state == DRAIN_OUT && out_ready) cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pq_sort_host.sv
module tb_pq_sort_host;
  import pq_pkg::*;

  localparam int unsigned MB = 4;
  localparam int unsigned CW = $clog2(MB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  kv_t           in_kv;
  logic          out_valid, out_ready, out_last;
  kv_t           out_kv;
  logic          pq_enq, pq_deq;
  kv_t           pq_kvi, pq_kvo;
  logic          pq_full, pq_empty, pq_busy;
  logic [CW-1:0] batch_len;
  logic          err;

  int unsigned num_checks = 0;
  int unsigned num_errors = 0;

  always #5 clk = ~clk;

  pq_sort_host #(.MAX_BATCH(MB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_kv(in_kv), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_kv(out_kv), .out_last(out_last),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_busy(pq_busy),
    .batch_len(batch_len), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic kv_t mkkv(input logic [7:0] k);
    return '{key: k, val: k ^ 8'h5A};
  endfunction

  // Behavioural PQ device: sorted storage, configurable capacity and
  // busy time after each command; head reads garbage while busy.
  kv_t         mem [8];
  int unsigned dcnt, busy_left;
  int unsigned busy_len = 0;
  int unsigned dev_cap  = 8;

  assign pq_empty = (dcnt == 0);
  assign pq_full  = (dcnt >= dev_cap);
  assign pq_busy  = (busy_left != 0);
  assign pq_kvo   = pq_busy ? kv_t'(16'hDEAD) : (dcnt == 0 ? KV0 : mem[0]);

  always @(posedge clk or negedge rst) begin : dev_model
    kv_t tmp [8];
    int  p;
    if (!rst) begin
      dcnt      <= 0;
      busy_left <= 0;
    end else begin
      tmp = mem;
      if (pq_enq && dcnt < 8) begin
        p = int'(dcnt);
        while (p > 0 && tmp[p-1].key > pq_kvi.key) begin
          tmp[p] = tmp[p-1];
          p--;
        end
        tmp[p] = pq_kvi;
        mem  <= tmp;
        dcnt <= dcnt + 1;
      end else if (pq_deq && dcnt > 0) begin
        for (int i = 0; i < 7; i++) tmp[i] = tmp[i+1];
        mem  <= tmp;
        dcnt <= dcnt - 1;
      end
      if (pq_enq || pq_deq)  busy_left <= busy_len;
      else if (busy_left != 0) busy_left <= busy_left - 1;
    end
  end

  // Command protocol monitor, sampled mid-cycle.
  logic        prev_cmd = 1'b0;
  int unsigned deq_cnt  = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_cmd <= 1'b0;
    end else begin
      if (pq_enq || pq_deq)
        check("cmd_rule", {29'd0, pq_busy, pq_enq && pq_deq, prev_cmd}, 32'd0);
      if (!pq_enq) check("kvi_idle", 32'(pq_kvi), 32'(KV0));
      if (pq_deq) deq_cnt <= deq_cnt + 1;
      prev_cmd <= pq_enq || pq_deq;
    end
  end

  logic [7:0] vin  [8];
  logic [7:0] vexp [8];

  task automatic send(input logic [7:0] k, input logic lst);
    int unsigned n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_kv    = mkkv(k);
    in_last  = lst;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("in_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_batch(input int n);
    for (int i = 0; i < n; i++) send(vin[i], i == n - 1);
  endtask

  task automatic collect(input int n, input int stall_at, input int stall_len);
    int got   = 0;
    int waitc = 0;
    int stall = stall_len;
    while (got < n) begin
      @(negedge clk);
      if (out_valid && got == stall_at && stall > 0) begin
        out_ready = 1'b0;
        check("stall_kv", 32'(out_kv), 32'(mkkv(vexp[got])));
        stall--;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          check("out_kv", 32'(out_kv), 32'(mkkv(vexp[got])));
          check("out_last", 32'(out_last), 32'(got == n - 1));
          got++;
          waitc = 0;
        end else if (++waitc > 300) begin
          check("out_timeout", 32'd1, 32'd0);
          got = n;
        end
      end
    end
    @(negedge clk);
    check("back_idle", 32'(dut.state), 32'(IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_kv = KV0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_kv", 32'(out_kv), 32'(KV0));
    check("rst_pq_enq", 32'(pq_enq), 32'd0);
    check("rst_pq_deq", 32'(pq_deq), 32'd0);
    check("rst_batch_len", 32'(batch_len), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b1;

    // Basic batch of four.
    vin = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd1, 8'd3, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    deq_cnt = 0;
    fork send_batch(4); collect(4, 99, 0); join
    check("b4_len", 32'(batch_len), 32'd4);
    check("b4_err", 32'(err), 32'd0);
    check("b4_deqs", deq_cnt, 32'd4);

    // Single item.
    vin[0] = 8'd7; vexp[0] = 8'd7;
    fork send_batch(1); collect(1, 99, 0); join
    check("b1_len", 32'(batch_len), 32'd1);
    check("b1_err", 32'(err), 32'd0);

    // Six items into a batch limit of four.
    vin = '{8'd10, 8'd60, 8'd30, 8'd50, 8'd20, 8'd40, 8'd0, 8'd0};
    vexp = '{8'd10, 8'd30, 8'd50, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0};
    fork
      send_batch(6);
      begin
        collect(4, 99, 0);
        check("trunc_err", 32'(err), 32'd1);
        check("trunc_len", 32'(batch_len), 32'd4);
        vexp[0] = 8'd20; vexp[1] = 8'd40;
        collect(2, 99, 0);
        check("rest_err", 32'(err), 32'd0);
        check("rest_len", 32'(batch_len), 32'd2);
      end
    join

    // Downstream stall of 10 cycles on the second output.
    vin = '{8'd8, 8'd2, 8'd6, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0};
    deq_cnt = 0;
    fork send_batch(4); collect(4, 1, 10); join
    check("stall_deqs", deq_cnt, 32'd4);

    // Slow device: busy for 3 cycles after every command.
    busy_len = 3;
    vin = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd1, 8'd3, 8'd5, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0};
    deq_cnt = 0;
    fork send_batch(4); collect(4, 99, 0); join
    check("busy_deqs", deq_cnt, 32'd4);
    check("busy_err", 32'(err), 32'd0);
    busy_len = 0;

    // Device fills at two entries: partial batch, then the remainder.
    dev_cap = 2;
    vin = '{8'd70, 8'd50, 8'd60, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vexp = '{8'd50, 8'd70, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    fork
      send_batch(3);
      begin
        collect(2, 99, 0);
        check("full_err", 32'(err), 32'd1);
        check("full_len", 32'(batch_len), 32'd2);
        vexp[0] = 8'd60;
        collect(1, 99, 0);
        check("full_rest_err", 32'(err), 32'd0);
      end
    join
    dev_cap = 8;

    // Reset while an output is being presented.
    vin[0] = 8'd30; vin[1] = 8'd20;
    fork
      send_batch(2);
      begin
        int unsigned n = 0;
        out_ready = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 300) begin
          @(negedge clk);
          n++;
        end
        check("rst_wait_out", 32'(out_valid), 32'd1);
      end
    join
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_pq_deq", 32'(pq_deq), 32'd0);
    check("arst_out_kv", 32'(out_kv), 32'(KV0));
    check("arst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    vin[0] = 8'd2; vin[1] = 8'd1;
    vexp[0] = 8'd1; vexp[1] = 8'd2;
    fork send_batch(2); collect(2, 99, 0); join
    check("post_rst_len", 32'(batch_len), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
